// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer_pkg
// Description : Shared types and constants for the fetch sequencer.
//               Provides the sequencer state encoding, the architectural
//               register and instruction widths, and the sequential PC step.
// Revision    : 1.0  initial release
// ============================================================================
package fetch_sequencer_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] PC_INC = 64'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

endpackage : fetch_sequencer_pkg
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Front-end controller of the pipeline. Owns the program
//               counter, presents it to the combinational fetch block,
//               registers each returned instruction into a one-entry
//               valid/ready buffer toward decode, applies redirects with a
//               buffer flush, and parks in FAULT on an invalid fetch address
//               until redirected.
// Ports       : clk, rst_n            clock, async active-low reset
//               if_pc                 PC driven into the fetch block
//               if_instruction        instruction returned for if_pc
//               if_inv_addr           if_pc misaligned / out of range
//               redirect_valid/_pc    branch/jump/trap redirect
//               out_valid/_ready      decode handshake
//               out_instruction/_pc   buffered instruction and its PC
//               fault, fault_pc       fault status and offending PC
//               fetch_count           completed handshakes, wraps mod 2^32
// Revision    : 1.0  initial release
// ============================================================================
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int          MEM_WORDS = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] if_pc,
    input  logic [ILEN-1:0] if_instruction,
    input  logic            if_inv_addr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ILEN-1:0] out_instruction,
    output logic [XLEN-1:0] out_pc,
    output logic            fault,
    output logic [XLEN-1:0] fault_pc,
    output logic [31:0]     fetch_count
);

    // Elaboration-time sanity checks on the configuration.
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("fetch_sequencer: RESET_PC must be word-aligned");
    end
    if (MEM_WORDS < 1) begin : g_bad_mem_words
        $error("fetch_sequencer: MEM_WORDS must be at least 1");
    end

    state_e          state_q;
    logic [XLEN-1:0] pc_q;
    logic            out_valid_q;
    logic [ILEN-1:0] out_instr_q;
    logic [XLEN-1:0] out_pc_q;
    logic            fault_q;
    logic [XLEN-1:0] fault_pc_q;
    logic [31:0]     fetch_count_q;

    logic            handshake;
    logic            buf_free;
    logic [XLEN-1:0] pc_seq_d;

    assign handshake = out_valid_q & out_ready;
    // The buffer can take a new instruction when empty or being drained now.
    assign buf_free  = ~out_valid_q | out_ready;
    assign pc_seq_d  = pc_q + PC_INC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            out_valid_q   <= 1'b0;
            out_instr_q   <= '0;
            out_pc_q      <= '0;
            fault_q       <= 1'b0;
            fault_pc_q    <= '0;
            fetch_count_q <= '0;
        end else begin
            // Delivery accounting is independent of the state machine.
            if (handshake) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_pc;
                    end
                    state_q <= ST_RUN;
                end

                ST_RUN: begin
                    if (redirect_valid) begin
                        pc_q        <= redirect_pc;
                        out_valid_q <= 1'b0;
                    end else if (buf_free) begin
                        if (!if_inv_addr) begin
                            out_instr_q <= if_instruction;
                            out_pc_q    <= pc_q;
                            out_valid_q <= 1'b1;
                            pc_q        <= pc_seq_d;
                        end else begin
                            fault_pc_q <= pc_q;
                            fault_q    <= 1'b1;
                            state_q    <= ST_FAULT;
                            // Only drop valid if the held entry left this cycle.
                            if (handshake) begin
                                out_valid_q <= 1'b0;
                            end
                        end
                    end
                end

                ST_FAULT: begin
                    if (redirect_valid) begin
                        pc_q        <= redirect_pc;
                        out_valid_q <= 1'b0;
                        fault_q     <= 1'b0;
                        state_q     <= ST_RUN;
                    end else if (handshake) begin
                        // A leftover buffered instruction may still drain.
                        out_valid_q <= 1'b0;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign if_pc           = pc_q;
    assign out_valid       = out_valid_q;
    assign out_instruction = out_instr_q;
    assign out_pc          = out_pc_q;
    assign fault           = fault_q;
    assign fault_pc        = fault_pc_q;
    assign fetch_count     = fetch_count_q;

endmodule : fetch_sequencer
`default_nettype wire
